// File: rtl/pdm_uart_frontend.sv
// pdm_uart_frontend
//   PDM microphone decimator plus 8N1 UART transmitter on one clock.
//   PDM half: divides clk into m_clk, samples m_data once per m_clk rising
//   edge and reports the ones-count of the last 200 samples every 100
//   samples, using two counters staggered by half a window.
//   UART half: sends one byte per tx_start, LSB first, one start and one
//   stop bit, DIV = round(CLK_FREQ*1e6/BAUD) clk per bit.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   m_clk, m_clk_en     microphone clock and its rising-edge strobe
//   m_data              PDM bitstream
//   amplitude[7:0]      ones-count 0..200, amplitude_valid one-clk pulse
//   data[7:0], tx_start byte to send and its one-clk request
//   tx_out, tx_done     serial line (idle high), end-of-frame pulse
module pdm_uart_frontend #(
  parameter int CLK_FREQ  = 44,
  parameter int MCLK_HALF = 10,
  parameter int BAUD      = 115200
) (
  input  logic       clk,
  input  logic       rst,
  output logic       m_clk,
  output logic       m_clk_en,
  input  logic       m_data,
  output logic [7:0] amplitude,
  output logic       amplitude_valid,
  input  logic [7:0] data,
  input  logic       tx_start,
  output logic       tx_done,
  output logic       tx_out
);
  localparam int DIV = (CLK_FREQ * 1000000 + BAUD / 2) / BAUD;
  localparam int DW  = $clog2(MCLK_HALF + 1);
  localparam int BW  = $clog2(DIV + 1);

  // ---------------- PDM clock ----------------
  logic [DW-1:0] div_q;
  logic          m_clk_q, m_clk_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      m_clk_q    <= 1'b0;
      m_clk_en_q <= 1'b0;
    end else begin
      m_clk_en_q <= 1'b0;
      if (div_q == DW'(MCLK_HALF - 1)) begin
        div_q      <= '0;
        m_clk_q    <= ~m_clk_q;
        // strobe lands in the same cycle m_clk first reads high
        m_clk_en_q <= ~m_clk_q;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  // ---------------- Decimation ----------------
  // pos_q = samples already in counter A's current window (0..199).
  // B runs the same 200-sample window offset by 100, so it closes when
  // pos_q is 99. B is armed after sample 100 and counts from sample 101.
  logic [7:0] pos_q, cnt_a_q, cnt_b_q, amp_q;
  logic       b_act_q, amp_vld_q;
  logic [7:0] a_sum_d, b_sum_d;

  assign a_sum_d = cnt_a_q + {7'd0, m_data};
  assign b_sum_d = cnt_b_q + {7'd0, m_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q     <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      b_act_q   <= 1'b0;
      amp_q     <= '0;
      amp_vld_q <= 1'b0;
    end else begin
      amp_vld_q <= 1'b0;
      if (m_clk_en_q) begin
        if (pos_q == 8'd199) begin
          pos_q     <= '0;
          cnt_a_q   <= '0;
          amp_q     <= a_sum_d;
          amp_vld_q <= 1'b1;
        end else begin
          pos_q   <= pos_q + 1'b1;
          cnt_a_q <= a_sum_d;
        end
        if (b_act_q) begin
          if (pos_q == 8'd99) begin
            cnt_b_q   <= '0;
            amp_q     <= b_sum_d;
            amp_vld_q <= 1'b1;
          end else begin
            cnt_b_q <= b_sum_d;
          end
        end else if (pos_q == 8'd99) begin
          b_act_q <= 1'b1;
        end
      end
    end
  end

  // ---------------- UART TX ----------------
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          tx_q, done_q;
  logic          baud_end;

  assign baud_end = (baud_q == BW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx_start) begin
            sh_q    <= data;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= sh_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              // sh_q[0] is the bit on the line; present the next one
              bit_q <= bit_q + 1'b1;
              tx_q  <= sh_q[1];
              sh_q  <= {1'b0, sh_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            baud_q  <= '0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_clk           = m_clk_q;
  assign m_clk_en        = m_clk_en_q;
  assign amplitude       = amp_q;
  assign amplitude_valid = amp_vld_q;
  assign tx_out          = tx_q;
  assign tx_done         = done_q;
endmodule

// File: tb/tb_pdm_uart_frontend.sv
module tb_pdm_uart_frontend;
  localparam int MH  = 10;
  localparam int DIV = 382;

  logic       clk, rst, m_clk, m_clk_en, m_data, amplitude_valid;
  logic       tx_start, tx_done, tx_out;
  logic [7:0] amplitude, data;
  int         errors = 0;
  int         checks = 0;

  pdm_uart_frontend dut (
    .clk(clk), .rst(rst), .m_clk(m_clk), .m_clk_en(m_clk_en), .m_data(m_data),
    .amplitude(amplitude), .amplitude_valid(amplitude_valid), .data(data),
    .tx_start(tx_start), .tx_done(tx_done), .tx_out(tx_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // PDM patterns: 0 zeros, 1 ones, 2 alternating (odd samples 1), 3 step after 250
  function automatic logic bit_for(input int mode, input int s);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return logic'(s % 2);
      default: return logic'(s > 250);
    endcase
  endfunction

  function automatic int exp_amp(input int mode, input int s);
    case (mode)
      0: return 0;
      1: return 200;
      2: return 100;
      default: case (s)
        200: return 0;
        300: return 50;
        400: return 150;
        500: return 200;
        default: return -1;
      endcase
    endcase
  endfunction

  // Runs nsamp samples from reset, checking each amplitude pulse position,
  // value and spacing; returns with the next expected pulse sample index.
  task automatic pdm_run(input int mode, input int nsamp, input int exp_next);
    int s = 0, nxt = 200, cyc = 0, lastv = -1;
    int budget = (nsamp + 2) * 2 * MH + 100;
    while (s < nsamp && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (amplitude_valid) begin
        chk($sformatf("amp_at_m%0d", mode), s, nxt);
        chk($sformatf("amp_m%0d_s%0d", mode, s), amplitude, exp_amp(mode, s));
        if (lastv >= 0) chk("amp_gap", cyc - lastv, 100 * 2 * MH);
        lastv = cyc;
        nxt += 100;
      end
      if (m_clk_en) begin
        s++;
        m_data = bit_for(mode, s);
      end
    end
    chk("pdm_budget", int'(s >= nsamp), 1);
    chk($sformatf("amp_count_m%0d", mode), nxt, exp_next);
  endtask

  // Sends one frame and checks every line cycle against {stop, d, start}.
  // poke: extra tx_start mid-frame. data is changed right after acceptance.
  task automatic uart_frame(input logic [7:0] d, input bit poke);
    logic [9:0] fr;
    int bad[10];
    int dones = 0;
    fr = {1'b1, d, 1'b0};
    foreach (bad[i]) bad[i] = 0;
    data = d;
    tx_start = 1'b1;
    for (int c = 1; c <= 10 * DIV + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin tx_start = 1'b0; data = ~d; end
      if (poke && c == 3 * DIV) tx_start = 1'b1;
      if (poke && c == 3 * DIV + 1) tx_start = 1'b0;
      if (c <= 10 * DIV) begin
        if (tx_out !== fr[(c - 1) / DIV]) bad[(c - 1) / DIV]++;
        if (tx_done) dones++;
      end
    end
    for (int i = 0; i < 10; i++) chk($sformatf("tx_%02h_bit%0d", d, i), bad[i], 0);
    chk("tx_done_early", dones, 0);
    chk("tx_done_pulse", tx_done, 1);
  endtask

  initial begin
    logic prev;
    int   last_t, first_rise, en_bad, dn, lows;
    rst = 1'b1; m_data = 1'b0; data = 8'h00; tx_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_m_clk", m_clk, 0);
    chk("rst_m_clk_en", m_clk_en, 0);
    chk("rst_amp", amplitude, 0);
    chk("rst_amp_vld", amplitude_valid, 0);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_tx_done", tx_done, 0);

    // m_clk toggles every MH clk, strobe exactly on each rising edge
    rst = 1'b0;
    prev = 1'b0; last_t = -1; first_rise = -1; en_bad = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (m_clk !== prev) begin
        if (last_t >= 0) chk("mclk_half", c - last_t, MH);
        last_t = c;
      end
      if (m_clk && !prev && first_rise < 0) first_rise = c;
      if (m_clk_en !== (m_clk && !prev)) en_bad++;
      prev = m_clk;
    end
    chk("mclk_first_rise", first_rise, MH);
    chk("mclk_en_mismatches", en_bad, 0);

    // all ones; stopped mid-window at sample 450 by the following reset
    do_reset();
    pdm_run(1, 450, 500);
    // zeros right after a mid-window reset: counters must have cleared
    do_reset();
    pdm_run(0, 301, 400);
    do_reset();
    pdm_run(2, 401, 500);
    do_reset();
    pdm_run(3, 501, 600);

    // UART: 0xA5 with an ignored mid-frame request, then back-to-back frames
    do_reset();
    uart_frame(8'hA5, 1'b1);
    uart_frame(8'h0F, 1'b0);   // request in the tx_done cycle
    @(negedge clk);
    uart_frame(8'hC3, 1'b0);   // request in the cycle after tx_done
    @(negedge clk);
    chk("tx_idle_after", tx_out, 1);

    // reset in the middle of data bit 1 (a 0 bit of 0x3C)
    data = 8'h3C;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (2 * DIV + DIV / 2) @(negedge clk);
    chk("pre_rst_tx_low", tx_out, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx_high", tx_out, 1);
    rst = 1'b0;
    dn = 0; lows = 0;
    repeat (10 * DIV + 10) begin
      @(negedge clk);
      if (tx_done) dn++;
      if (!tx_out) lows++;
    end
    chk("rst_mid_no_done", dn, 0);
    chk("rst_mid_line_idle", lows, 0);
    uart_frame(8'h3C, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
